immgen_stream: RTL and testbench

IMMGEN_STREAM -- requirements
Module: immgen_stream

---
 rtl/immgen_pkg.sv | 27 ++
 rtl/immgen_stream_if.sv | 24 ++
 rtl/imm_fifo.sv | 49 ++++
 rtl/immgen_stream.sv | 68 ++++++
 tb/tb_immgen_stream.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/immgen_pkg.sv
// immgen_pkg: opcodes, format codes and buffer entry type shared by immgen_stream
package immgen_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_t;

    // every RV immediate fits in 32 signed bits; widening to XLEN happens at the output
    typedef struct packed {
        logic [31:0] imm;
        fmt_t        fmt;
        logic        illegal;
    } entry_t;
endpackage

// File: rtl/immgen_stream_if.sv
// immgen_stream_if: instruction input stream and decoded immediate output stream
interface immgen_stream_if #(
    parameter int XLEN = 32
);
    import immgen_pkg::*;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instrucao;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imediatoGerado;
    fmt_t            out_fmt;
    logic            out_illegal;
    logic [15:0]     illegal_count;

    modport master (
        output in_valid, instrucao, out_ready,
        input  in_ready, out_valid, imediatoGerado, out_fmt, out_illegal, illegal_count
    );
    modport slave (
        input  in_valid, instrucao, out_ready,
        output in_ready, out_valid, imediatoGerado, out_fmt, out_illegal, illegal_count
    );
endinterface

// File: rtl/imm_fifo.sv
// imm_fifo: DEPTH-entry FIFO without pop bypass; shows the last popped word while empty
module imm_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  last;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? last : mem[rd_ptr];

    // storage needs no reset: it is only visible while occupied
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last   <= mem[rd_ptr];
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/immgen_stream.sv
// immgen_stream: RISC-V immediate decoder into an output FIFO; define IMMGEN_STREAM_UJ_EN to decode U/J formats
module immgen_stream
    import immgen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input logic            clock,
    input logic            reset,
    immgen_stream_if.slave bus
);
    entry_t      ent, head;
    logic        full, empty, push, pop;
    logic [31:0] ins;

    assign ins = bus.instrucao;

    // decode the offered word by opcode alone
    always_comb begin
        ent = '{imm: 32'd0, fmt: FMT_NONE, illegal: 1'b1};
        case (ins[6:0])
            OP_LOAD, OP_OPIMM, OP_JALR:
                ent = '{imm: {{20{ins[31]}}, ins[31:20]}, fmt: FMT_I, illegal: 1'b0};
            OP_STORE:
                ent = '{imm: {{20{ins[31]}}, ins[31:25], ins[11:7]}, fmt: FMT_S, illegal: 1'b0};
            OP_BRANCH:
                ent = '{imm: {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, fmt: FMT_B, illegal: 1'b0};
`ifdef IMMGEN_STREAM_UJ_EN
            OP_LUI, OP_AUIPC:
                ent = '{imm: {ins[31:12], 12'd0}, fmt: FMT_U, illegal: 1'b0};
            OP_JAL:
                ent = '{imm: {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, fmt: FMT_J, illegal: 1'b0};
`endif
            default: ;
        endcase
    end

`ifndef IMMGEN_STREAM_UJ_EN
    logic unused_ins;
    assign unused_ins = ^ins[19:12];
`endif

    assign push = bus.in_valid && !full;
    assign pop  = !empty && bus.out_ready;

    imm_fifo #(.DEPTH(DEPTH), .W($bits(entry_t))) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (ent),
        .full  (full),
        .empty (empty),
        .dout  (head)
    );

    assign bus.in_ready       = !full;
    assign bus.out_valid      = !empty;
    assign bus.imediatoGerado = XLEN'($signed(head.imm));
    assign bus.out_fmt        = head.fmt;
    assign bus.out_illegal    = head.illegal;

    // count accepted unsupported opcodes, saturating
    always_ff @(posedge clock or posedge reset) begin
        if (reset) bus.illegal_count <= '0;
        else if (push && ent.illegal && bus.illegal_count != 16'hFFFF) bus.illegal_count <= bus.illegal_count + 16'd1;
    end
endmodule

// File: tb/tb_immgen_stream.sv
// tb_immgen_stream: directed stimulus checked against a field-arithmetic queue model
module tb_immgen_stream;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam logic [63:0] MASK = (XLEN == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;

    typedef struct {
        longint   imm;
        int       fmt;
        bit       ill;
    } mexp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    mexp_t mq[$];
    int   mcnt = 0;
    bit   m_push, m_pop;

    immgen_stream_if #(.XLEN(XLEN)) bus ();

    immgen_stream #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic mexp_t model(input logic [31:0] w);
        longint s;
        mexp_t  e;
        s = longint'($signed(w));
        e = '{0, 0, 1'b1};
        case (w[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: e = '{s >>> 20, 1, 1'b0};
            7'b0100011: e = '{((s >>> 25) <<< 5) + longint'(w[11:7]), 2, 1'b0};
            7'b1100011: e = '{((s >>> 31) <<< 12) + (longint'(w[7]) << 11) + (longint'(w[30:25]) << 5) + (longint'(w[11:8]) << 1), 3, 1'b0};
`ifdef IMMGEN_STREAM_UJ_EN
            7'b0110111, 7'b0010111: e = '{(s >>> 12) <<< 12, 4, 1'b0};
            7'b1101111: e = '{((s >>> 31) <<< 20) + (longint'(w[19:12]) << 12) + (longint'(w[20]) << 11) + (longint'(w[30:21]) << 1), 5, 1'b0};
`endif
            default: ;
        endcase
        return e;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
            mcnt = 0;
        end else begin
            m_pop  = mq.size() > 0 && bus.out_ready;
            m_push = bus.in_valid && mq.size() < DEPTH;
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back(model(bus.instrucao));
                if (mq[mq.size()-1].ill && mcnt < 65535) mcnt++;
            end
        end
    end

    always @(negedge clock) begin
        chk("in_ready", 64'(bus.in_ready), 64'(reset || mq.size() < DEPTH));
        chk("out_valid", 64'(bus.out_valid), 64'(!reset && mq.size() > 0));
        chk("illegal_count", 64'(bus.illegal_count), 64'(mcnt));
        if (reset) begin
            chk("rst_imm", 64'(bus.imediatoGerado), 64'd0);
            chk("rst_fmt", 64'(bus.out_fmt), 64'd0);
            chk("rst_illegal", 64'(bus.out_illegal), 64'd0);
        end else if (mq.size() > 0) begin
            chk("head_imm", 64'(bus.imediatoGerado), mq[0].imm & MASK);
            chk("head_fmt", 64'(bus.out_fmt), 64'(mq[0].fmt));
            chk("head_illegal", 64'(bus.out_illegal), 64'(mq[0].ill));
        end
    end

    task automatic drive(input logic v, input logic [31:0] w, input logic r);
        @(negedge clock);
        bus.in_valid  = v;
        bus.instrucao = w;
        bus.out_ready = r;
    endtask

    task automatic head_chk(input string name, input logic [63:0] imm, input logic [63:0] fmt, input logic [63:0] ill);
        chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({name, "_imm"}, 64'(bus.imediatoGerado), imm);
        chk({name, "_fmt"}, 64'(bus.out_fmt), fmt);
        chk({name, "_illegal"}, 64'(bus.out_illegal), ill);
    endtask

    logic [31:0] tbl [8] = '{32'h7FF02083, 32'h80000067, 32'h80000023, 32'h7E000FE3,
                             32'h00001017, 32'h800000EF, 32'h0000000F, 32'hFFFFFFFF};

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.instrucao = 32'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_imm", 64'(bus.imediatoGerado), 64'd0);
        reset = 1'b0;

        drive(1, 32'hFFF00093, 0);
        drive(0, 0, 0);
        head_chk("addi", 64'hFFFF_FFFF, 1, 0);
        drive(0, 0, 1);
        drive(0, 0, 0);
        chk("addi_drained", 64'(bus.out_valid), 64'd0);

        drive(1, 32'hFE112E23, 1);
        drive(1, 32'hFE000CE3, 1);
        head_chk("sw", 64'hFFFF_FFFC, 2, 0);
        drive(0, 0, 1);
        head_chk("beq", 64'hFFFF_FFF8, 3, 0);
        drive(0, 0, 0);
        chk("swbeq_drained", 64'(bus.out_valid), 64'd0);

        drive(1, 32'h123450B7, 0);
        drive(0, 0, 0);
`ifdef IMMGEN_STREAM_UJ_EN
        head_chk("lui", 64'h1234_5000, 4, 0);
        chk("lui_count", 64'(bus.illegal_count), 64'd0);
`else
        head_chk("lui", 64'd0, 0, 1);
        chk("lui_count", 64'(bus.illegal_count), 64'd1);
`endif
        drive(0, 0, 1);
        drive(1, 32'h0080006F, 0);
        drive(0, 0, 0);
`ifdef IMMGEN_STREAM_UJ_EN
        head_chk("jal", 64'd8, 5, 0);
`else
        head_chk("jal", 64'd0, 0, 1);
        chk("jal_count", 64'(bus.illegal_count), 64'd2);
`endif
        drive(0, 0, 1);
        drive(1, 32'h7FF02083, 0);
        drive(0, 0, 0);
        head_chk("lw", 64'h7FF, 1, 0);
        drive(0, 0, 1);
        drive(0, 0, 0);

        for (int i = 0; i < 16; i++) drive(1, tbl[i % 8], 1'(i % 3 != 0));
        repeat (4) drive(0, 0, 1);
        drive(0, 0, 0);
        chk("mix_drained", 64'(bus.out_valid), 64'd0);

        drive(1, 32'h00100093, 0);
        drive(1, 32'h00200093, 0);
        head_chk("fill_a", 64'd1, 1, 0);
        drive(1, 32'h00300093, 0);
        chk("full_ready", 64'(bus.in_ready), 64'd0);
        drive(1, 32'h00300093, 0);
        chk("hold_ready", 64'(bus.in_ready), 64'd0);
        head_chk("hold_a", 64'd1, 1, 0);
        drive(1, 32'h00300093, 1);
        chk("nobypass_ready", 64'(bus.in_ready), 64'd0);
        drive(1, 32'h00300093, 0);
        chk("freed_ready", 64'(bus.in_ready), 64'd1);
        head_chk("order_b", 64'd2, 1, 0);
        drive(0, 0, 1);
        chk("c_taken_ready", 64'(bus.in_ready), 64'd0);
        head_chk("still_b", 64'd2, 1, 0);
        drive(0, 0, 1);
        head_chk("order_c", 64'd3, 1, 0);
        drive(0, 0, 0);
        chk("abc_drained", 64'(bus.out_valid), 64'd0);

        for (int i = 0; i < 32'h10005; i++) drive(1, 32'h00000033, 1);
        drive(0, 0, 1);
        chk("sat_count", 64'(bus.illegal_count), 64'hFFFF);
        head_chk("rtype", 64'd0, 0, 1);
        drive(0, 0, 0);

        drive(1, 32'h00100093, 0);
        drive(1, 32'h00200093, 0);
        drive(1, 32'h00300093, 0);
        chk("pre_reset_valid", 64'(bus.out_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_in_ready", 64'(bus.in_ready), 64'd1);
        chk("async_imm", 64'(bus.imediatoGerado), 64'd0);
        chk("async_fmt", 64'(bus.out_fmt), 64'd0);
        chk("async_illegal", 64'(bus.out_illegal), 64'd0);
        chk("async_count", 64'(bus.illegal_count), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        drive(0, 0, 0);
        chk("post_reset_valid", 64'(bus.out_valid), 64'd0);
        chk("post_reset_ready", 64'(bus.in_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
